// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-network result path.
package nn_pkg;

  localparam int NN_CLASSES = 10;
  localparam int NN_PROB_W  = 16;

  typedef logic [NN_PROB_W-1:0] prob_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/nn_result_argmax.sv
// Sequential argmax over a snapshot of class probabilities: digit, max score and winning margin.
// Optional confidence flag enabled by defining NN_ARGMAX_CONF_THRESH_EN.
module nn_result_argmax
  import nn_pkg::*;
#(
  parameter int          N_CLASSES = NN_CLASSES,
  parameter int          PROB_W    = NN_PROB_W,
  parameter int unsigned THRESH    = 32'h0000_8000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PROB_W-1:0] Probability [N_CLASSES-1:0],
  output logic              Busy,
  output logic              Done,
  output logic              Valid,
  output logic [3:0]        Digit,
  output logic [PROB_W-1:0] Max_Prob,
  output logic [PROB_W-1:0] Margin
`ifdef NN_ARGMAX_CONF_THRESH_EN
  ,
  output logic              Confident
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(N_CLASSES - 1);

  // Reject configurations the 4-bit digit and the threshold width cannot represent.
  if (N_CLASSES < 2 || N_CLASSES > 16 || 64'(THRESH) >= (64'd1 << PROB_W)) begin : g_bad_params
    $error("nn_result_argmax: illegal parameter combination");
  end

  argmax_state_t state, state_next;

  logic [PROB_W-1:0] snap [N_CLASSES-1:0];
  logic [3:0]        idx;
  logic [3:0]        best_idx;
  logic [PROB_W-1:0] best_val;
  logic [PROB_W-1:0] second_val;
  logic [PROB_W-1:0] cur_val;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
  end

  assign cur_val = snap[idx];

  // Strict greater-than keeps the lower index on ties while still letting the tie raise second_val.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx        <= 4'd0;
      best_idx   <= 4'd0;
      best_val   <= '0;
      second_val <= '0;
      Done       <= 1'b0;
      Valid      <= 1'b0;
      Digit      <= 4'd0;
      Max_Prob   <= '0;
      Margin     <= '0;
`ifdef NN_ARGMAX_CONF_THRESH_EN
      Confident  <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            snap       <= Probability;
            best_idx   <= 4'd0;
            best_val   <= Probability[0];
            second_val <= '0;
            idx        <= 4'd1;
          end
        end
        SCAN: begin
          if (cur_val > best_val) begin
            second_val <= best_val;
            best_val   <= cur_val;
            best_idx   <= idx;
          end else if (cur_val > second_val) begin
            second_val <= cur_val;
          end
          idx <= idx + 4'd1;
        end
        DONE: begin
          Done     <= 1'b1;
          Valid    <= 1'b1;
          Digit    <= best_idx;
          Max_Prob <= best_val;
          Margin   <= best_val - second_val;
`ifdef NN_ARGMAX_CONF_THRESH_EN
          Confident <= (best_val >= PROB_W'(THRESH));
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_result_argmax.sv
// Self-checking bench for nn_result_argmax: directed scans with a result scoreboard.
// Confidence checks are compiled in when NN_ARGMAX_CONF_THRESH_EN is defined.
module tb_nn_result_argmax;

  localparam int N     = 10;
  localparam int PW    = 16;
  localparam int LIMIT = 40;

  typedef struct {
    logic [3:0]    digit;
    logic [PW-1:0] maxp;
    logic [PW-1:0] margin;
    logic          conf;
  } result_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [PW-1:0] prob [N-1:0];
  logic          busy;
  logic          done;
  logic          valid;
  logic [3:0]    digit;
  logic [PW-1:0] max_prob;
  logic [PW-1:0] margin;
`ifdef NN_ARGMAX_CONF_THRESH_EN
  logic          confident;
`endif

  int checks   = 0;
  int failures = 0;
  result_t sb[$];

  nn_result_argmax #(.N_CLASSES(N), .PROB_W(PW), .THRESH(32'h8000)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .Probability(prob),
    .Busy       (busy),
    .Done       (done),
    .Valid      (valid),
    .Digit      (digit),
    .Max_Prob   (max_prob),
    .Margin     (margin)
`ifdef NN_ARGMAX_CONF_THRESH_EN
    ,
    .Confident  (confident)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: lowest index of the maximum wins; second is the best of all other entries.
  function automatic result_t model(input logic [PW-1:0] p [N-1:0]);
    result_t r;
    logic [PW-1:0] sec;
    r.digit = 4'd0;
    r.maxp  = p[0];
    for (int i = 1; i < N; i++)
      if (p[i] > r.maxp) begin
        r.maxp  = p[i];
        r.digit = 4'(i);
      end
    sec = '0;
    for (int i = 0; i < N; i++)
      if (i != int'(r.digit) && p[i] > sec) sec = p[i];
    r.margin = r.maxp - sec;
    r.conf   = (r.maxp >= 16'h8000);
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check_output("done_without_expectation", 32'(sb.size()), 32'd1);
      end else begin
        result_t e;
        e = sb.pop_front();
        check_output("sb_digit", 32'(digit), 32'(e.digit));
        check_output("sb_max_prob", 32'(max_prob), 32'(e.maxp));
        check_output("sb_margin", 32'(margin), 32'(e.margin));
        check_output("sb_valid", 32'(valid), 32'd1);
        check_output("sb_busy_in_done", 32'(busy), 32'd0);
`ifdef NN_ARGMAX_CONF_THRESH_EN
        check_output("sb_confident", 32'(confident), 32'(e.conf));
`endif
      end
    end
  end

  // Begins just after a negedge; returns one negedge after the Done pulse.
  task automatic apply_stimulus(input logic [PW-1:0] p [N-1:0], input bit clear_after,
                                input int inj_a, input int inj_b);
    int cycles;
    int busy_cycles;
    bit seen;
    prob  = p;
    start = 1'b1;
    sb.push_back(model(p));
    cycles      = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (!seen && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
      start = (cycles == inj_a || cycles == inj_b);
      if (clear_after)
        for (int i = 0; i < N; i++) prob[i] = '0;
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    start = 1'b0;
    check_output("start_to_done_latency", 32'(cycles - 1), 32'(N));
    check_output("busy_cycle_count", 32'(busy_cycles), 32'(N));
    @(negedge clk);
    check_output("done_one_cycle", 32'(done), 32'd0);
  endtask

  logic [PW-1:0] pat [N-1:0];
  int done_at [$];
  int cyc;
  int extra_busy;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) prob[i] = '0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_valid", 32'(valid), 32'd0);
    check_output("reset_digit", 32'(digit), 32'd0);
    check_output("reset_max_prob", 32'(max_prob), 32'd0);
    check_output("reset_margin", 32'(margin), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single winner");
    for (int i = 0; i < N; i++) pat[i] = '0;
    pat[3] = 16'h1234; pat[7] = 16'hF000; pat[9] = 16'h0100;
    apply_stimulus(pat, 1'b0, 0, 0);
    check_output("winner_digit", 32'(digit), 32'd7);
    check_output("winner_max", 32'(max_prob), 32'hF000);
    check_output("winner_margin", 32'(margin), 32'hDDCC);
    repeat (4) @(negedge clk);
    check_output("winner_hold_digit", 32'(digit), 32'd7);

    $display("[TB] tie");
    for (int i = 0; i < N; i++) pat[i] = '0;
    pat[2] = 16'h4000; pat[5] = 16'h4000;
    apply_stimulus(pat, 1'b0, 0, 0);
    check_output("tie_digit", 32'(digit), 32'd2);
    check_output("tie_margin", 32'(margin), 32'd0);

    $display("[TB] snapshot isolation");
    for (int i = 0; i < N; i++) pat[i] = '0;
    pat[9] = 16'hFFFF;
    apply_stimulus(pat, 1'b1, 0, 0);
    check_output("snap_digit", 32'(digit), 32'd9);
    check_output("snap_max", 32'(max_prob), 32'hFFFF);

    $display("[TB] start ignored while scanning and in the final state cycle");
    for (int i = 0; i < N; i++) pat[i] = 16'(i * 16'h0111);
    pat[4] = 16'hABCD;
    apply_stimulus(pat, 1'b0, 4, N);
    extra_busy = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) extra_busy++;
    end
    check_output("no_restart_busy", 32'(extra_busy), 32'd0);

    $display("[TB] held start");
    for (int i = 0; i < N; i++) pat[i] = 16'(16'h0800 + i);
    pat[6] = 16'h9001;
    for (int s = 0; s < 3; s++) sb.push_back(model(pat));
    prob  = pat;
    start = 1'b1;
    cyc   = 0;
    while (done_at.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) done_at.push_back(cyc);
    end
    start = 1'b0;
    check_output("held_done_count", 32'(done_at.size()), 32'd3);
    if (done_at.size() == 3) begin
      check_output("held_period_1", 32'(done_at[1] - done_at[0]), 32'(N + 1));
      check_output("held_period_2", 32'(done_at[2] - done_at[1]), 32'(N + 1));
    end
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-scan");
    for (int i = 0; i < N; i++) pat[i] = 16'h0F00;
    prob  = pat;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) reset = 1'b1;
    end
    check_output("midreset_busy", 32'(busy), 32'd0);
    check_output("midreset_valid", 32'(valid), 32'd0);
    check_output("midreset_digit", 32'(digit), 32'd0);
    check_output("midreset_max", 32'(max_prob), 32'd0);
    check_output("midreset_margin", 32'(margin), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) pat[i] = 16'($urandom_range(0, 16'hFFFF));
    apply_stimulus(pat, 1'b0, 0, 0);

    $display("[TB] all zero");
    for (int i = 0; i < N; i++) pat[i] = '0;
    apply_stimulus(pat, 1'b0, 0, 0);
    check_output("zero_digit", 32'(digit), 32'd0);
    check_output("zero_max", 32'(max_prob), 32'd0);
    check_output("zero_margin", 32'(margin), 32'd0);

    $display("[TB] random vectors");
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) pat[i] = 16'($urandom_range(0, 16'hFFFF));
      apply_stimulus(pat, 1'b0, 0, 0);
    end

`ifdef NN_ARGMAX_CONF_THRESH_EN
    $display("[TB] confidence threshold");
    for (int i = 0; i < N; i++) pat[i] = 16'h0010;
    pat[1] = 16'h7FFF;
    apply_stimulus(pat, 1'b0, 0, 0);
    check_output("conf_below", 32'(confident), 32'd0);
    pat[1] = 16'h8000;
    apply_stimulus(pat, 1'b0, 0, 0);
    check_output("conf_at", 32'(confident), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_result_argmax.md
# nn_result_argmax

Sequential classifier back-end that sits directly downstream of `neural_network`. When the network signals `Ready`, it snapshots the ten per-class probabilities and scans them one class per cycle. It tracks the best and second-best scores, then registers the predicted digit, its score and the winning margin for the HEX/LED display path. Results hold until the next completed scan.

## Interface
Parameters:
- `N_CLASSES`, 10: number of classes scanned; legal range 2..16.
- `PROB_W`, 16: probability width; values are unsigned.
- `THRESH`, 16'h8000: confidence threshold. Used only when `CONF_THRESH_EN` is defined.

Ports:
- `Clk` input, 1: system clock (MAX10_CLK1_50 domain).
- `Reset` input, 1: synchronous, active-high reset.
- `Start` input, 1: request a scan; driven by `neural_network.Ready`.
- `Probability` input, [PROB_W-1:0] x [N_CLASSES-1:0]: unpacked array of class scores.
- `Busy` output, 1: scan in progress.
- `Done` output, 1: one-cycle pulse when new results are registered.
- `Valid` output, 1: at least one scan has completed since reset.
- `Digit` output, 4: index of the highest score.
- `Max_Prob` output, PROB_W: highest score.
- `Margin` output, PROB_W: highest score minus second-highest score.
- `Confident` output, 1: present only with `CONF_THRESH_EN`.

## Operation
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - `Start`=1 at an edge snapshots all `Probability` entries into an internal register array.
  - The same edge loads best = (idx 0, p[0]) and second = 0, sets the index counter to 1 and enters SCAN.
- SCAN, one class per cycle at counter i:
  - If p[i] > best: second ← best value, best ← (i, p[i]).
  - Else if p[i] > second: second ← p[i].
  - The comparison is strict, so ties keep the lower index as best; an equal value still updates second.
  - When i = N_CLASSES-1, the FSM goes to DONE after this compare.
- DONE, lasting one cycle:
  - `Digit`, `Max_Prob`, `Margin` (= best − second, never negative, no wrap possible) and `Confident` are registered as outputs.
  - `Done`=1 and `Valid`←1; the next state is IDLE.
- `Start` while in SCAN is ignored, with no restart and no queueing.
- `Start` in the DONE cycle is also ignored. `Start` is level-sampled only in IDLE, so a held-high `Start` retriggers a new scan every N_CLASSES+1 cycles.
- Changes to `Probability` after the snapshot edge have no effect on the scan in progress.
- Result outputs change only in DONE; otherwise they hold their values.
- All-zero inputs give `Digit`=0, `Max_Prob`=0, `Margin`=0.
- Reset in any state, including mid-scan, returns the FSM to IDLE and discards the partial scan. Reset values: `Busy`=0, `Done`=0, `Valid`=0, `Digit`=0, `Max_Prob`=0, `Margin`=0, `Confident`=0.
- `Reset` has priority over `Start` at the same edge.

## Timing
- `Start` sampled at edge k (FSM in IDLE):
  - `Busy`=1 for the cycles after edges k .. k+N_CLASSES-1.
  - Results and `Done` are visible after edge k+N_CLASSES; `Done` is high for exactly one cycle.
  - `Busy`=0 during the `Done` cycle.
- Latency from `Start` to `Done` is N_CLASSES cycles, which is 10 at the default.
- The earliest next accepted `Start` is at edge k+N_CLASSES+1.
- Throughput is one result per N_CLASSES+1 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `NN_ARGMAX_CONF_THRESH_EN` defined:
  - The `Confident` port exists.
  - `Confident` is registered in DONE as `Max_Prob` >= `THRESH`; its reset value is 0.
- `NN_ARGMAX_CONF_THRESH_EN` undefined:
  - The `Confident` port and its logic are absent; `THRESH` is unused.
  - All other behaviour is identical.

## Structure
- Shared package `nn_pkg` holds:
  - the constants `NN_CLASSES` = 10 and `NN_PROB_W` = 16;
  - `typedef logic [NN_PROB_W-1:0] prob_t`;
  - the state enum `argmax_state_t` {IDLE, SCAN, DONE}.
- No sub-module is required. The compare/update step is inline `always_ff` logic with a single comparator pair.

## Test plan
- Single winner:
  - Stimulus: p = {0,0,0,16'h1234,0,0,0,16'hF000,0,16'h0100}, indices 0..9; pulse `Start`.
  - Response: exactly 10 cycles later `Done`=1 for one cycle, `Digit`=7, `Max_Prob`=F000, `Margin`=DDCC, `Valid`=1.
- Tie:
  - Stimulus: p[2] = p[5] = 16'h4000, all others 0.
  - Response: `Digit`=2, `Margin`=0.
- Snapshot isolation:
  - Stimulus: `Start` with p[9] = FFFF (others 0), then change p to all 0 on the next cycle.
  - Response: result `Digit`=9, `Max_Prob`=FFFF.
- Busy protocol:
  - Stimulus: pulse `Start` in SCAN and again in the DONE cycle.
  - Response: both pulses are ignored and only one `Done` occurs. `Start` held high produces a `Done` every 11 cycles.
- Reset mid-scan:
  - Stimulus: assert `Reset` at scan cycle 5.
  - Response: next cycle all outputs are 0 and the FSM is in IDLE. A fresh `Start` then completes normally.
- Confidence, macro defined, `THRESH`=8000:
  - Stimulus: max 7FFF, then 8000.
  - Response: `Confident`=0, then 1.
